// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter.
// The CPU writes a byte into a one-deep holding register at offset 0x00.
// STATUS at offset 0x04 reports busy, holding-full and a sticky overrun flag.
// The overrun flag is cleared by writing 1 to bit 2 of STATUS.
module uart_tx_periph #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Sel,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              TX,
  output logic              Busy,
  output logic              Irq_empty
);

  localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_TC    = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-3:0] IDX_DATA   = '0;
  localparam logic [ADDR_W-3:0] IDX_STATUS = (ADDR_W-2)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              hold_full_q, hold_full_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        holding_q;
  logic [7:0]        shift_q;

  logic [ADDR_W-3:0] addr_idx;
  logic              sel_data, sel_status;
  logic              wr_data, wr_status;
  logic              baud_tc;
  logic              xfer;
  logic              load_hold;
  logic              unused_bits;

  // Word-aligned decode; the byte lane bits and upper write data are don't-care.
  assign addr_idx    = Addr[ADDR_W-1:2];
  assign sel_data    = (addr_idx == IDX_DATA);
  assign sel_status  = (addr_idx == IDX_STATUS);
  assign wr_data     = Sel & MemWrite & sel_data;
  assign wr_status   = Sel & MemWrite & sel_status;
  assign baud_tc     = (baud_q == BAUD_TC);
  assign unused_bits = ^{WD[31:8], Addr[1:0]};

  // Transmit FSM next state, baud/bit counters and next TX level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (hold_full_q) begin
          xfer    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          // Back-to-back frames: a pending byte skips IDLE entirely.
          if (hold_full_q) begin
            xfer    = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Holding-register occupancy and sticky overrun; a set on the same edge beats W1C.
  always_comb begin
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;
    load_hold   = 1'b0;
    if (wr_status && WD[2]) begin
      ovr_d = 1'b0;
    end
    if (wr_data) begin
      if (!hold_full_q || xfer) begin
        load_hold   = 1'b1;
        hold_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      hold_full_d = 1'b0;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
    end
  end

  // Byte storage; validity is tracked by hold_full, so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (load_hold) begin
      holding_q <= WD[7:0];
    end
    if (xfer) begin
      shift_q <= holding_q;
    end
  end

  // Combinational read mux; DATA and unmapped offsets read as zero.
  always_comb begin
    RD = 32'd0;
    if (Sel && sel_status) begin
      RD = {29'd0, ovr_q, hold_full_q, (state_q != IDLE)};
    end
  end

  assign TX        = tx_q;
  assign Busy      = (state_q != IDLE);
  assign Irq_empty = ~hold_full_q;

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter peripheral. It is the responder on the peripheral side of the multicycle CPU's data bus, selected when the control unit drives IntorPeri.
- CPU stores a byte into a one-deep holding register.
- The block serialises it as 8N1, LSB first, on TX.
- CPU polls a status register for busy, holding-full and overrun.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
ADDR_W, 8, width of the peripheral offset address.

Ports:
CLK  in  1  system clock, rising-edge.
CLR  in  1  reset, synchronous, active-low.
Sel  in  1  peripheral select (IntorPeri from the control unit).
MemWrite  in  1  write strobe; write takes effect on the rising edge while Sel=1.
Addr  in  ADDR_W  byte offset within the peripheral.
WD  in  32  write data.
RD  out  32  read data, combinational from Addr and registers.
TX  out  1  serial line, registered, idle high.
Busy  out  1  1 while a frame is being shifted (state != IDLE).
Irq_empty  out  1  1 when the holding register is empty (registered level).

Behaviour:
- One clock; all state updates occur on the rising CLK edge. Reset is synchronous and active-low on CLR, sampled on the rising edge.
- Reset values: TX=1, state=IDLE, hold_full=0, ovr=0, bit counter=0, baud counter=0, Busy=0, Irq_empty=1.
- Reset during a frame aborts it; TX=1 from the edge at which CLR=0 is sampled. Holding-register contents are discarded.
- Register map (Addr, word-aligned; Addr[1:0] ignored):
  - 0x00 DATA: write-only. Write loads WD[7:0] into the holding register; WD[31:8] ignored. Reads 0.
  - 0x04 STATUS: RD = {29'b0, ovr, hold_full, busy}. Write with WD[2]=1 clears ovr (W1C); other bits read-only.
  - Any other offset: reads 0, writes ignored.
- Read path: when Sel=0, RD=0. Reads have no side effects.
- DATA write, Sel=1 and MemWrite=1 and Addr=0x00:
  - hold_full=0: holding <= WD[7:0], hold_full <= 1.
  - hold_full=1 and no transfer to the shifter on the same edge: write dropped, holding unchanged, ovr <= 1.
  - hold_full=1 and a transfer on the same edge: the shifter takes the old holding byte, the new byte is stored, hold_full stays 1, no overrun.
- Transmit FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1 in each bit.
  - IDLE: TX=1. If hold_full, the next edge goes to START, shift <= holding, hold_full <= 0, TX <= 0.
  - START: TX=0 for CLKS_PER_BIT cycles, then DATA with bit index 0 and TX <= shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7, go to STOP with TX <= 1.
  - STOP: TX=1 for CLKS_PER_BIT cycles. At the end, if hold_full, go directly to START (back-to-back, identical transfer actions as IDLE). Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: a write on edge N gives TX low from edge N+1, when the FSM is idle.
- Busy = (state != IDLE). Irq_empty = ~hold_full.
- Overrun set and W1C clear on the same edge: set wins, ovr=1.
- The bit counter is 3 bits. The baud counter is ceil(log2(CLKS_PER_BIT)) bits and wraps only through an explicit reset to 0 at terminal count.

Test Plan:
- CLKS_PER_BIT=4. Reset, then read STATUS -> RD=0x0, TX=1, Irq_empty=1.
- Write 0xA5 to 0x00 at edge N:
  - TX=0 over cycles N+1..N+4.
  - Then data bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each.
  - Then TX=1 for 4 cycles.
  - Busy=1 for exactly 40 cycles. STATUS=0x0 afterwards.
- Write 0x55, then 0x0F while the first frame shifts:
  - STATUS=0x3 during frame 1.
  - Frame 2 START begins immediately after frame 1 STOP; no idle gap.
  - Both bytes received intact by the bench UART monitor.
- Write three bytes during one frame -> third byte dropped, STATUS=0x7.
  - Write 0x4 to 0x04 -> ovr cleared, STATUS bit2=0.
  - Only two frames are observed on TX.
- Overrun and W1C on the same edge -> ovr remains 1. Read 0x08 -> RD=0. Sel=0 with Addr=0x04 -> RD=0.
- Assert CLR=0 for one edge mid-DATA bit 3:
  - TX=1 and Busy=0 from that edge.
  - hold_full=0; no further frame output.
